// File: rtl/fpaddsub_pkg.sv
// Shared widths, pass limit and FSM state type for the shared alignment shifter.
package fpaddsub_pkg;

  localparam int unsigned MW       = 32;
  localparam int unsigned EW       = 8;
  localparam int unsigned MAX_PASS = 31;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

endpackage

// File: rtl/fpaddsub_align_arbiter_if.sv
// Request lanes and result port of the shared alignment shifter.
interface fpaddsub_align_arbiter_if;
  import fpaddsub_pkg::*;

  logic          req0_valid;
  logic          req0_ready;
  logic [MW-1:0] req0_mant;
  logic [EW-1:0] req0_shift;

  logic          req1_valid;
  logic          req1_ready;
  logic [MW-1:0] req1_mant;
  logic [EW-1:0] req1_shift;

  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic          out_sticky;
  logic          out_id;

  modport master (
    output req0_valid, req0_mant, req0_shift,
    input  req0_ready,
    output req1_valid, req1_mant, req1_shift,
    input  req1_ready,
    input  out_valid, out_mant, out_sticky, out_id,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_mant, req0_shift,
    output req0_ready,
    input  req1_valid, req1_mant, req1_shift,
    output req1_ready,
    output out_valid, out_mant, out_sticky, out_id,
    input  out_ready
  );

endinterface

// File: rtl/fpaddsub_align_stage.sv
// One combinational alignment pass: logical right shift by 0..31 with a sticky OR of lost bits.
module fpaddsub_align_stage
  import fpaddsub_pkg::*;
(
  input  logic [MW-1:0] mant,
  input  logic [4:0]    amt,
  output logic [MW-1:0] shifted,
  output logic          sticky
);

  // Lower half of the extended word collects every bit shifted out past bit 0.
  logic [2*MW-1:0] ext;
  logic [2*MW-1:0] step16;
  logic [2*MW-1:0] coarse;
  logic [2*MW-1:0] fine;

  assign ext    = {mant, {MW{1'b0}}};
  assign step16 = amt[4] ? (ext >> 16) : ext;

  always_comb begin
    coarse = step16;
    unique case (amt[3:2])
      2'd0: coarse = step16;
      2'd1: coarse = step16 >> 4;
      2'd2: coarse = step16 >> 8;
      2'd3: coarse = step16 >> 12;
    endcase
  end

  always_comb begin
    fine = coarse;
    unique case (amt[1:0])
      2'd0: fine = coarse;
      2'd1: fine = coarse >> 1;
      2'd2: fine = coarse >> 2;
      2'd3: fine = coarse >> 3;
    endcase
  end

  assign shifted = fine[2*MW-1:MW];
  assign sticky  = |fine[MW-1:0];

endmodule

// File: rtl/fpaddsub_align_arbiter.sv
// Round-robin arbiter sharing one iterative mantissa alignment shifter between two add/sub lanes.
module fpaddsub_align_arbiter
  import fpaddsub_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  fpaddsub_align_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          id_q, id_d;
  logic          sticky_q, sticky_d;
  logic [MW-1:0] mant_q, mant_d;
  logic [EW-1:0] rem_q, rem_d;

  logic          grant0, grant1;
  logic [4:0]    pass_amt;
  logic [MW-1:0] stage_mant;
  logic          stage_sticky;

  assign pass_amt = (rem_q > EW'(MAX_PASS)) ? 5'(MAX_PASS) : rem_q[4:0];

  fpaddsub_align_stage u_stage (
    .mant    (mant_q),
    .amt     (pass_amt),
    .shifted (stage_mant),
    .sticky  (stage_sticky)
  );

  // Lane ptr has priority; a lone valid lane wins regardless of ptr.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (bus.req0_valid && (!ptr_q || !bus.req1_valid)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    sticky_d = sticky_q;
    mant_d   = mant_q;
    rem_d    = rem_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          id_d     = grant1;
          ptr_d    = ~grant1;
          mant_d   = grant1 ? bus.req1_mant : bus.req0_mant;
          rem_d    = grant1 ? bus.req1_shift : bus.req0_shift;
          sticky_d = 1'b0;
          state_d  = (rem_d == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (mant_q == '0) begin
          // Nothing left to shift out; skip the remaining passes.
          rem_d   = '0;
          state_d = DONE;
        end else begin
          mant_d   = stage_mant;
          sticky_d = sticky_q | stage_sticky;
          rem_d    = rem_q - EW'(pass_amt);
          if (rem_q == EW'(pass_amt)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      sticky_q <= 1'b0;
      mant_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      sticky_q <= sticky_d;
      mant_q   <= mant_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_mant   = mant_q;
  assign bus.out_sticky = sticky_q;
  assign bus.out_id     = id_q;

endmodule

// File: tb/tb_fpaddsub_align_arbiter.sv
// Randomized and directed bench for the shared alignment shifter against a cycle-level model.
module tb_fpaddsub_align_arbiter;
  import fpaddsub_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpaddsub_align_arbiter_if bus_if ();

  fpaddsub_align_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results from the arithmetic meaning of the operation.
  function automatic logic [31:0] ref_mant(input logic [31:0] m, input int sh);
    return (sh >= 32) ? 32'd0 : (m >> sh);
  endfunction

  function automatic logic ref_sticky(input logic [31:0] m, input int sh);
    logic [31:0] mask;
    if (sh == 0) return 1'b0;
    if (sh >= 32) return |m;
    mask = (32'h1 << sh) - 32'h1;
    return |(m & mask);
  endfunction

  // Passes: ceil(sh/31), cut short one pass after the mantissa has been fully drained.
  function automatic int ref_passes(input logic [31:0] m, input int sh);
    int full, msb, k;
    if (sh == 0) return 0;
    full = (sh + 30) / 31;
    if (m == 32'd0) return 1;
    msb = 0;
    for (int i = 0; i < 32; i++) if (m[i]) msb = i;
    k = (msb + 1 + 30) / 31;
    return (k + 1 < full) ? k + 1 : full;
  endfunction

  // Model state shared with the stimulus process.
  logic        mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  logic        mdl_ptr = 1'b0;
  logic [31:0] exp_m = '0;
  logic        exp_s = 1'b0;
  logic        exp_id = 1'b0;
  logic        just_reset = 1'b0;
  logic        acc0 = 1'b0;
  logic        acc1 = 1'b0;

  initial begin
    logic g0, g1, exp_ov;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("ready0_rst", 64'(bus_if.req0_ready), 64'd0);
        chk("ready1_rst", 64'(bus_if.req1_ready), 64'd0);
        mdl_busy   = 1'b0;
        mdl_ptr    = 1'b0;
        just_reset = 1'b1;
        acc0       = 1'b0;
        acc1       = 1'b0;
      end else begin
        g0 = !mdl_busy && bus_if.req0_valid && (!mdl_ptr || !bus_if.req1_valid);
        g1 = !mdl_busy && bus_if.req1_valid && !g0;
        exp_ov = mdl_busy && (mdl_cnt == 0);
        chk("ready0", 64'(bus_if.req0_ready), 64'(g0));
        chk("ready1", 64'(bus_if.req1_ready), 64'(g1));
        chk("out_valid", 64'(bus_if.out_valid), 64'(exp_ov));
        if (exp_ov) begin
          chk("out_mant", 64'(bus_if.out_mant), 64'(exp_m));
          chk("out_sticky", 64'(bus_if.out_sticky), 64'(exp_s));
          chk("out_id", 64'(bus_if.out_id), 64'(exp_id));
        end
        if (just_reset) begin
          chk("rst_out_mant", 64'(bus_if.out_mant), 64'd0);
          chk("rst_out_sticky", 64'(bus_if.out_sticky), 64'd0);
          chk("rst_out_id", 64'(bus_if.out_id), 64'd0);
          just_reset = 1'b0;
        end
        acc0 = bus_if.req0_valid && bus_if.req0_ready;
        acc1 = bus_if.req1_valid && bus_if.req1_ready;
        if (mdl_busy) begin
          if (mdl_cnt > 0) mdl_cnt--;
          else if (bus_if.out_ready) mdl_busy = 1'b0;
        end else if (g0 || g1) begin
          exp_id   = g1;
          exp_m    = g1 ? ref_mant(bus_if.req1_mant, int'(bus_if.req1_shift))
                        : ref_mant(bus_if.req0_mant, int'(bus_if.req0_shift));
          exp_s    = g1 ? ref_sticky(bus_if.req1_mant, int'(bus_if.req1_shift))
                        : ref_sticky(bus_if.req0_mant, int'(bus_if.req0_shift));
          mdl_cnt  = g1 ? ref_passes(bus_if.req1_mant, int'(bus_if.req1_shift))
                        : ref_passes(bus_if.req0_mant, int'(bus_if.req0_shift));
          mdl_busy = 1'b1;
          mdl_ptr  = ~g1;
        end
      end
    end
  end

  task automatic set_lane(input bit lane, input logic v, input logic [31:0] m, input int sh);
    if (lane) begin
      bus_if.req1_valid = v; bus_if.req1_mant = m; bus_if.req1_shift = 8'(sh);
    end else begin
      bus_if.req0_valid = v; bus_if.req0_mant = m; bus_if.req0_shift = 8'(sh);
    end
  endtask

  // Wait for the lane's grant, then drop its valid just after the accept edge.
  task automatic wait_accept(input bit lane, input string name);
    bit got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (lane ? bus_if.req1_ready : bus_if.req0_ready) begin
        got = 1;
        break;
      end
    end
    chk({name, "_accept"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    if (lane) bus_if.req1_valid = 1'b0;
    else bus_if.req0_valid = 1'b0;
  endtask

  task automatic wait_out(input bit id, input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus_if.out_valid) begin
        lat = i;
        break;
      end
    end
    chk({name, "_seen"}, 64'(lat != 0), 64'd1);
    chk({name, "_id"}, 64'(bus_if.out_id), 64'(id));
  endtask

  task automatic run_one(input bit lane, input logic [31:0] m, input int sh,
                         input logic [31:0] em, input logic es, input int elat,
                         input string name);
    int lat;
    @(posedge clk);
    #1;
    set_lane(lane, 1'b1, m, sh);
    wait_accept(lane, name);
    wait_out(lane, name, lat);
    chk({name, "_lat"}, 64'(lat), 64'(elat));
    chk({name, "_mant"}, 64'(bus_if.out_mant), 64'(em));
    chk({name, "_sticky"}, 64'(bus_if.out_sticky), 64'(es));
  endtask

  function automatic int rand_shift();
    unique case ($urandom_range(0, 4))
      0: return 0;
      1: return int'($urandom_range(1, 31));
      2: return int'($urandom_range(32, 255));
      3: return ($urandom_range(0, 1) != 0) ? 255 : 31;
      default: return ($urandom_range(0, 1) != 0) ? 32 : 62;
    endcase
  endfunction

  function automatic logic [31:0] rand_mant();
    unique case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'h1 << $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    set_lane(1'b0, 1'b0, '0, 0);
    set_lane(1'b1, 1'b0, '0, 0);
    bus_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_one(1'b0, 32'h8000_0000, 4, 32'h0800_0000, 1'b0, 2, "single");
    run_one(1'b1, 32'h8000_0001, 40, 32'h0, 1'b1, 3, "multi");
    run_one(1'b0, 32'h0000_0001, 200, 32'h0, 1'b1, 3, "early_out");
    run_one(1'b1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1, "zero_shift");
    run_one(1'b0, 32'h7FFF_FFFF, 31, 32'h0, 1'b1, 2, "shift31");
    run_one(1'b1, 32'h8000_0000, 32, 32'h0, 1'b1, 3, "shift32");
    run_one(1'b0, 32'hF000_0000, 28, 32'h0000_000F, 1'b0, 2, "shift28");

    // Arbitration: contention straight out of reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    set_lane(1'b0, 1'b1, 32'h0000_0003, 1);
    set_lane(1'b1, 1'b1, 32'h0000_0007, 2);
    @(negedge clk);
    chk("arb_first_r0", 64'(bus_if.req0_ready), 64'd1);
    chk("arb_first_r1", 64'(bus_if.req1_ready), 64'd0);
    @(posedge clk); #1 bus_if.req0_valid = 1'b0;
    wait_out(1'b0, "arb_first", lat);
    wait_accept(1'b1, "arb_second");
    set_lane(1'b0, 1'b1, 32'h0000_00F0, 4);
    set_lane(1'b1, 1'b1, 32'h0000_0F00, 8);
    wait_out(1'b1, "arb_second", lat);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_if.req0_ready || bus_if.req1_ready) break;
    end
    chk("arb_third_r0", 64'(bus_if.req0_ready), 64'd1);
    chk("arb_third_r1", 64'(bus_if.req1_ready), 64'd0);
    @(posedge clk); #1 bus_if.req0_valid = 1'b0;
    wait_out(1'b0, "arb_third", lat);
    wait_accept(1'b1, "arb_fourth");
    wait_out(1'b1, "arb_fourth", lat);

    // Backpressure: result must hold while out_ready is low.
    @(posedge clk);
    #1 bus_if.out_ready = 1'b0;
    set_lane(1'b0, 1'b1, 32'h1234_5678, 8);
    wait_accept(1'b0, "bp");
    set_lane(1'b1, 1'b1, 32'h0000_0100, 3);
    wait_out(1'b0, "bp", lat);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus_if.out_valid), 64'd1);
      chk("bp_mant", 64'(bus_if.out_mant), 64'h0012_3456);
      chk("bp_sticky", 64'(bus_if.out_sticky), 64'd1);
      chk("bp_ready1", 64'(bus_if.req1_ready), 64'd0);
    end
    @(posedge clk); #1 bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 64'(bus_if.out_valid), 64'd1);
    @(negedge clk);
    chk("bp_after_valid", 64'(bus_if.out_valid), 64'd0);
    chk("bp_after_ready1", 64'(bus_if.req1_ready), 64'd1);
    wait_accept(1'b1, "bp_next");
    wait_out(1'b1, "bp_next", lat);

    // Reset during a long shift: the in-flight result must never appear.
    @(posedge clk); #1;
    set_lane(1'b0, 1'b1, 32'hFFFF_FFFF, 255);
    wait_accept(1'b0, "rst_mid");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      chk("rst_mid_no_stale", 64'(bus_if.out_valid), 64'd0);
    end
    run_one(1'b1, 32'h0000_0010, 4, 32'h0000_0001, 1'b0, 2, "rst_recover");

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      if (acc0) bus_if.req0_valid = 1'b0;
      if (acc1) bus_if.req1_valid = 1'b0;
      if (!bus_if.req0_valid && $urandom_range(0, 99) < 40)
        set_lane(1'b0, 1'b1, rand_mant(), rand_shift());
      if (!bus_if.req1_valid && $urandom_range(0, 99) < 40)
        set_lane(1'b1, 1'b1, rand_mant(), rand_shift());
      bus_if.out_ready = ($urandom_range(0, 99) < 70);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (acc0) bus_if.req0_valid = 1'b0;
      if (acc1) bus_if.req1_valid = 1'b0;
      bus_if.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("drain_idle", 64'(bus_if.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
